// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control FSM: opcodes, FSM states
// and the datapath mux/ALU select codes.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_FAULT
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Memory handshake and datapath control bundle between the control FSM
// (master) and the datapath/memory (slave).
interface multicycle_control_if;
  logic       mem_req;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;

  modport master (
    output mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
    input  mem_ready
  );

  modport slave (
    input  mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
    output mem_ready
  );
endinterface

// File: rtl/mc_output_decode.sv
// Combinational state-to-control decode for the multi-cycle FSM.
// The JAL state decode exists only when MCCTRL_JAL_EN is defined.
module mc_output_decode
  import rv_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp
);
  logic pc_update;
  logic branch;

  always_comb begin
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    pc_update = 1'b0;
    branch    = 1'b0;
    case (state)
      S_FETCH: begin
        // IR load and PC+4 commit only once the instruction word is actually back
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_MEM;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_SUB;
        branch  = 1'b1;
      end
`ifdef MCCTRL_JAL_EN
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign PCWrite = pc_update | (branch & zero);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control FSM with memory stall watchdog, sticky fault and
// retired-instruction counter. Define MCCTRL_JAL_EN to accept jal.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            opcode,
  input  logic                  zero,
  multicycle_control_if.master  bus,
  output logic                  fault,
  output logic [1:0]            fault_code,
  output logic [CNT_W-1:0]      instret
);
  localparam int                STALL_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

  state_t               state_q;
  state_t               state_d;
  logic [6:0]           opcode_q;
  logic [STALL_W-1:0]   stall_q;
  logic [1:0]           code_d;
  logic [1:0]           code_q;
  logic                 fault_q;
  logic [CNT_W-1:0]     instret_q;
  logic                 stall_expired;
  logic                 retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // A ready in the last permitted stall cycle still completes the access
  assign stall_expired = bus.mem_req && !bus.mem_ready && (stall_q == STALL_LAST);

  always_comb begin
    state_d = state_q;
    code_d  = FC_NONE;
    case (state_q)
      S_FETCH: if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYP:      state_d = S_EXECR;
          OP_ITYP:      state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
`ifdef MCCTRL_JAL_EN
          OP_JAL:       state_d = S_JAL;
`endif
          default: begin
            state_d = S_FAULT;
            code_d  = FC_ILLEGAL;
          end
        endcase
      end
      S_MEMADR:   state_d = (opcode_q == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
`ifdef MCCTRL_JAL_EN
      S_JAL:      state_d = S_ALUWB;
`endif
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FAULT;
    endcase
    if (stall_expired) begin
      state_d = S_FAULT;
      code_d  = FC_TIMEOUT;
    end
  end

  mc_output_decode u_decode (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .zero      (zero),
    .mem_req   (bus.mem_req),
    .PCWrite   (bus.PCWrite),
    .AdrSrc    (bus.AdrSrc),
    .MemWrite  (bus.MemWrite),
    .IRWrite   (bus.IRWrite),
    .RegWrite  (bus.RegWrite),
    .ResultSrc (bus.ResultSrc),
    .ALUSrcA   (bus.ALUSrcA),
    .ALUSrcB   (bus.ALUSrcB),
    .ALUOp     (bus.ALUOp)
  );

  assign retire = (state_d == S_FETCH) &&
                  (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q  <= '0;
      stall_q   <= '0;
      fault_q   <= 1'b0;
      code_q    <= FC_NONE;
      instret_q <= '0;
    end else begin
      if (state_q == S_DECODE) opcode_q <= opcode;
      if (bus.mem_ready || (state_d != state_q)) stall_q <= '0;
      else if (bus.mem_req)                      stall_q <= stall_q + 1'b1;
      if ((state_q != S_FAULT) && (state_d == S_FAULT)) begin
        fault_q <= 1'b1;
        code_q  <= code_d;
      end
      if (retire) instret_q <= instret_q + 1'b1;
    end
  end

  assign fault      = fault_q;
  assign fault_code = code_q;
  assign instret    = instret_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Opcode-driven control FSM for the multi-cycle RISC-V core, successor to the single-cycle main control unit. It sequences fetch, decode, execute, memory and writeback over several clocks, sharing one ALU and one unified memory port. It adds a memory ready handshake with a stall watchdog, fault reporting and a retired-instruction counter. It sits between the instruction register (opcode input) and the datapath muxes and enables.

## Interface
- TIMEOUT_CYCLES, 16: maximum consecutive stalled cycles before a fault; legal values ≥2.
- CNT_W, 32: width of the retired-instruction counter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  instr[6:0] from the instruction register; sampled in DECODE only.
- zero  in  1  ALU zero flag; used in BEQ only.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- PCWrite  out  1  PC enable (pc_update | (Branch & zero)).
- AdrSrc  out  1  0 = PC, 1 = ALUOut as the memory address.
- MemWrite, IRWrite, RegWrite  out  1 each  write enables.
- ResultSrc  out  2  00 ALUOut, 01 memory data, 10 ALU result.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1.
- ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4.
- ALUOp  out  2  00 add, 01 sub, 10 funct decode.
- fault  out  1  sticky fault.
- fault_code  out  2  00 none, 01 illegal opcode, 10 memory timeout.
- instret  out  CNT_W  retired-instruction count.

## Operation
- Outputs are a Moore decode of the state. Every output not listed for a state is 0.
- FETCH: mem_req, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and pc_update are asserted only in the cycle where mem_ready=1. The FSM stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL (only with the macro)
  - anything else → FAULT with code 01
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD for lw, MEMWRITE for sw; the opcode is latched in DECODE.
- MEMREAD: mem_req, AdrSrc=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite. Goes to FETCH.
- MEMWRITE: mem_req, AdrSrc=1, MemWrite. MemWrite is held for the whole stall. Goes to FETCH on mem_ready.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite. Goes to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch. Goes to FETCH.
- FAULT: all enables 0, mem_req=0. The FSM stays here until reset. fault=1, fault_code holds its code.
- Stall counter:
  - Increments each cycle with mem_req & !mem_ready.
  - Clears on mem_ready or on any state change.
  - At count TIMEOUT_CYCLES-1 with mem_ready still low, the next state is FAULT with code 10.
  - mem_ready in that same cycle wins; no fault is raised.
- instret:
  - +1 on each transition into FETCH from MEMWB, MEMWRITE (on mem_ready), ALUWB or BEQ.
  - Wraps modulo 2^CNT_W. FAULT never retires an instruction.

## Timing
- Reset (async, rst_n=0): state=FETCH, stall counter=0, instret=0, fault=0, fault_code=00, latched opcode=0. Outputs therefore show the FETCH decode with mem_req=1 and IRWrite=0.
- Latency with zero wait states (mem_ready=1 on the first cycle of each access): lw 5, sw 4, R 4, I 4, jal 4, beq 3 cycles. Each stall cycle adds 1.
- Deasserting rst_n mid-instruction aborts it: the counters are cleared and no retire is counted.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.

## Configuration
- MCCTRL_JAL_EN defined: JAL state is present. In JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, pc_update. Goes to ALUWB (writes PC+4 to rd, ALUOut holds the target from DECODE).
- MCCTRL_JAL_EN undefined: opcode 1101111 is illegal and goes to FAULT with code 01.

## Structure
- Package rv_ctrl_pkg holds the opcode localparams, the state enum, and the ALUOp, ResultSrc, ALUSrcA and ALUSrcB encodings.
- One sub-module, mc_output_decode: purely combinational, maps state, mem_ready and zero to all datapath controls. The top keeps the state register, next-state logic, stall counter, fault registers and instret.

## Test plan
- Reset with rst_n=0 → mem_req=1, IRWrite=0, PCWrite=0, fault=0, instret=0.
- lw (0000011), mem_ready always 1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB in 5 cycles, RegWrite only in MEMWB, instret=1.
- sw (0100011) with mem_ready low for 2 cycles in MEMWRITE → MemWrite=1 for 3 cycles, 6 cycles total, instret=1.
- TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH → FAULT after 4 cycles, fault_code=10, mem_req=0 thereafter. Repeat with mem_ready=1 in the 4th cycle → no fault.
- opcode 1111111 → FAULT with code 01. jal (1101111) → 4-cycle retire with the macro, FAULT code 01 without it.
- CNT_W=4, 16 back-to-back beq with zero=1 → PCWrite pulses in each BEQ state, instret wraps to 0.
